response_router: RTL and testbench

Return-path companion to the request-side validity filter. It takes up to three compacted memory response lanes, each tagged with the originating port ID (1..3, 0 = invalid) and a 2-bit request tag, and steers each response back to its originating port. Responses are buffered per port in a small show-ahead FIFO with valid/ready output handshake. Sits between the memory bank read outputs and the three client ports.

---
 rtl/response_router_pkg.sv | 16 +
 rtl/resp_fifo.sv | 61 ++++++
 rtl/response_router.sv | 131 +++++++++++++
 tb/tb_response_router.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_router_pkg.sv
// Shared constants for the response return path: port IDs and the tag width.
package response_router_pkg;

    localparam int unsigned TAG_W     = 2;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned NUM_PORTS = 3;

    typedef logic [ID_W-1:0] port_id_t;

    localparam port_id_t PORT_ID_INVALID = ID_W'(0);
    localparam port_id_t PORT_ID_1       = ID_W'(1);
    localparam port_id_t PORT_ID_2       = ID_W'(2);
    localparam port_id_t PORT_ID_3       = ID_W'(3);

endpackage

// File: rtl/resp_fifo.sv
// Show-ahead FIFO: the head entry is presented from storage, and reads zero when empty.
module resp_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c,
    output logic             overflow_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_c    = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop && !empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push    = push && (!full || do_pop);
    assign overflow_c = push && full && !do_pop;
    assign head_c     = empty_c ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/response_router.sv
// Steers up to three memory response lanes back to their originating client ports,
// buffering each port in its own FIFO and recording sticky error flags.
module response_router
    import response_router_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lane1_in,
    input  logic [ID_W-1:0]  lane1_id,
    input  logic [TAG_W-1:0] lane1_req_tag_in,
    input  logic             lane1_in_valid,
    input  logic [WIDTH-1:0] lane2_in,
    input  logic [ID_W-1:0]  lane2_id,
    input  logic [TAG_W-1:0] lane2_req_tag_in,
    input  logic             lane2_in_valid,
    input  logic [WIDTH-1:0] lane3_in,
    input  logic [ID_W-1:0]  lane3_id,
    input  logic [TAG_W-1:0] lane3_req_tag_in,
    input  logic             lane3_in_valid,
    output logic [WIDTH-1:0] port1_out,
    output logic [TAG_W-1:0] port1_req_tag_out,
    output logic             port1_out_valid,
    input  logic             port1_out_ready,
    output logic [WIDTH-1:0] port2_out,
    output logic [TAG_W-1:0] port2_req_tag_out,
    output logic             port2_out_valid,
    input  logic             port2_out_ready,
    output logic [WIDTH-1:0] port3_out,
    output logic [TAG_W-1:0] port3_req_tag_out,
    output logic             port3_out_valid,
    input  logic             port3_out_ready,
    output logic [2:0]       err_overflow,
    output logic             err_collision,
    output logic             err_bad_id,
    input  logic             err_clr
);

    localparam int unsigned PW = WIDTH + TAG_W;

    logic [NUM_LANES-1:0] lane_valid;
    port_id_t             lane_id      [NUM_LANES];
    logic [PW-1:0]        lane_payload [NUM_LANES];

    logic [NUM_PORTS-1:0] push;
    logic [PW-1:0]        push_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_ready;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] overflow;
    logic [PW-1:0]        head [NUM_PORTS];
    logic                 bad_id_c;
    logic                 collision_c;

    assign lane_valid      = {lane3_in_valid, lane2_in_valid, lane1_in_valid};
    assign lane_id[0]      = lane1_id;
    assign lane_id[1]      = lane2_id;
    assign lane_id[2]      = lane3_id;
    assign lane_payload[0] = {lane1_req_tag_in, lane1_in};
    assign lane_payload[1] = {lane2_req_tag_in, lane2_in};
    assign lane_payload[2] = {lane3_req_tag_in, lane3_in};
    assign port_ready      = {port3_out_ready, port2_out_ready, port1_out_ready};

    // Lanes are scanned in ascending order, so the lowest lane claims a port first.
    always_comb begin
        push        = '0;
        bad_id_c    = 1'b0;
        collision_c = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            push_data[p] = '0;
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_valid[l]) begin
                if (lane_id[l] == PORT_ID_INVALID) begin
                    bad_id_c = 1'b1;
                end
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (lane_id[l] == port_id_t'(p + 1)) begin
                        if (push[p]) begin
                            collision_c = 1'b1;
                        end else begin
                            push[p]      = 1'b1;
                            push_data[p] = lane_payload[l];
                        end
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        resp_fifo #(
            .WIDTH (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[p]),
            .push_data  (push_data[p]),
            .pop        (port_ready[p]),
            .head_c     (head[p]),
            .empty_c    (empty[p]),
            .overflow_c (overflow[p])
        );
    end

    assign port1_out         = head[0][WIDTH-1:0];
    assign port1_req_tag_out = head[0][PW-1:WIDTH];
    assign port1_out_valid   = !empty[0];
    assign port2_out         = head[1][WIDTH-1:0];
    assign port2_req_tag_out = head[1][PW-1:WIDTH];
    assign port2_out_valid   = !empty[1];
    assign port3_out         = head[2][WIDTH-1:0];
    assign port3_req_tag_out = head[2][PW-1:WIDTH];
    assign port3_out_valid   = !empty[2];

    // Sticky flags: a new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow  <= '0;
            err_collision <= 1'b0;
            err_bad_id    <= 1'b0;
        end else begin
            err_overflow  <= (err_clr ? 3'b000 : err_overflow) | overflow;
            err_collision <= (err_clr ? 1'b0 : err_collision) | collision_c;
            err_bad_id    <= (err_clr ? 1'b0 : err_bad_id) | bad_id_c;
        end
    end

endmodule

// File: tb/tb_response_router.sv
// Randomised scoreboard bench for response_router with a per-port queue reference model.
module tb_response_router;
    import response_router_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned PW    = WIDTH + TAG_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] l_data [3];
    logic [ID_W-1:0]  l_id   [3];
    logic [TAG_W-1:0] l_tag  [3];
    logic             l_valid[3];
    logic [WIDTH-1:0] p_out  [3];
    logic [TAG_W-1:0] p_tag  [3];
    logic             p_valid[3];
    logic             p_ready[3];
    logic [2:0]       err_overflow;
    logic             err_collision;
    logic             err_bad_id;
    logic             err_clr;

    // Stimulus staged by the sequence, applied by step()
    logic             s_valid[3];
    logic [ID_W-1:0]  s_id   [3];
    logic [TAG_W-1:0] s_tag  [3];
    logic [WIDTH-1:0] s_data [3];
    logic             s_ready[3];
    logic             s_clr;

    // Reference model: queue of outstanding responses per port and sticky flags
    logic [PW-1:0]    exp_q [3][$];
    int               pushed_now [3];
    logic [2:0]       nxt_ovf, vis_ovf;
    logic             nxt_coll, vis_coll, nxt_bad, vis_bad;
    bit               mon_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    response_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lane1_in          (l_data[0]),
        .lane1_id          (l_id[0]),
        .lane1_req_tag_in  (l_tag[0]),
        .lane1_in_valid    (l_valid[0]),
        .lane2_in          (l_data[1]),
        .lane2_id          (l_id[1]),
        .lane2_req_tag_in  (l_tag[1]),
        .lane2_in_valid    (l_valid[1]),
        .lane3_in          (l_data[2]),
        .lane3_id          (l_id[2]),
        .lane3_req_tag_in  (l_tag[2]),
        .lane3_in_valid    (l_valid[2]),
        .port1_out         (p_out[0]),
        .port1_req_tag_out (p_tag[0]),
        .port1_out_valid   (p_valid[0]),
        .port1_out_ready   (p_ready[0]),
        .port2_out         (p_out[1]),
        .port2_req_tag_out (p_tag[1]),
        .port2_out_valid   (p_valid[1]),
        .port2_out_ready   (p_ready[1]),
        .port3_out         (p_out[2]),
        .port3_req_tag_out (p_tag[2]),
        .port3_out_valid   (p_valid[2]),
        .port3_out_ready   (p_ready[2]),
        .err_overflow      (err_overflow),
        .err_collision     (err_collision),
        .err_bad_id        (err_bad_id),
        .err_clr           (err_clr)
    );

    task automatic chk(input string name, input int port, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s port%0d @%0t: got %0h expected %0h", name, port + 1, $time, act, exp);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            s_valid[i] = 1'b0;
            s_id[i]    = '0;
            s_tag[i]   = '0;
            s_data[i]  = '0;
        end
        s_clr = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [ID_W-1:0] id, input logic [TAG_W-1:0] tag,
                            input logic [WIDTH-1:0] data);
        s_valid[l] = 1'b1;
        s_id[l]    = id;
        s_tag[l]   = tag;
        s_data[l]  = data;
    endtask

    task automatic set_ready(input logic r1, input logic r2, input logic r3);
        s_ready[0] = r1;
        s_ready[1] = r2;
        s_ready[2] = r3;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            exp_q[p].delete();
            pushed_now[p] = 0;
        end
        nxt_ovf = '0; vis_ovf = '0;
        nxt_coll = 1'b0; vis_coll = 1'b0;
        nxt_bad = 1'b0; vis_bad = 1'b0;
    endtask

    // Apply staged inputs for the coming edge and advance the model to match.
    task automatic step();
        int         occ [3];
        bit         pop_m [3];
        bit         claimed [3];
        logic [2:0] ovf_ev;
        bit         coll_ev, bad_ev;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            l_valid[i] = s_valid[i];
            l_id[i]    = s_id[i];
            l_tag[i]   = s_tag[i];
            l_data[i]  = s_data[i];
            p_ready[i] = s_ready[i];
        end
        err_clr  = s_clr;
        vis_ovf  = nxt_ovf;
        vis_coll = nxt_coll;
        vis_bad  = nxt_bad;
        ovf_ev   = '0;
        coll_ev  = 0;
        bad_ev   = 0;
        for (int p = 0; p < 3; p++) begin
            occ[p]        = exp_q[p].size();
            pop_m[p]      = s_ready[p] && (occ[p] > 0);
            claimed[p]    = 0;
            pushed_now[p] = 0;
        end
        for (int l = 0; l < 3; l++) begin
            if (s_valid[l]) begin
                if (s_id[l] == 0) begin
                    bad_ev = 1;
                end else begin
                    int p;
                    p = int'(s_id[l]) - 1;
                    if (claimed[p]) begin
                        coll_ev = 1;
                    end else begin
                        claimed[p] = 1;
                        if (occ[p] < DEPTH || pop_m[p]) begin
                            exp_q[p].push_back({s_tag[l], s_data[l]});
                            pushed_now[p] = 1;
                        end else begin
                            ovf_ev[p] = 1'b1;
                        end
                    end
                end
            end
        end
        nxt_ovf  = (s_clr ? 3'b000 : nxt_ovf) | ovf_ev;
        nxt_coll = (s_clr ? 1'b0 : nxt_coll) | coll_ev;
        nxt_bad  = (s_clr ? 1'b0 : nxt_bad) | bad_ev;
    endtask

    // Monitor: compares visible outputs mid-cycle and retires heads that will be consumed.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int p = 0; p < 3; p++) begin
                    bit            mv;
                    logic [PW-1:0] e;
                    mv = (exp_q[p].size() - pushed_now[p]) > 0;
                    chk("out_valid", p, 32'(p_valid[p]), 32'(mv));
                    if (mv) begin
                        e = exp_q[p][0];
                        chk("out_data", p, 32'(p_out[p]), 32'(e[WIDTH-1:0]));
                        chk("out_tag", p, 32'(p_tag[p]), 32'(e[PW-1:WIDTH]));
                        if (p_ready[p]) begin
                            void'(exp_q[p].pop_front());
                        end
                    end else begin
                        chk("empty_data", p, 32'(p_out[p]), 32'h0);
                        chk("empty_tag", p, 32'(p_tag[p]), 32'h0);
                    end
                end
                chk("err_overflow", -1, 32'(err_overflow), 32'(vis_ovf));
                chk("err_collision", -1, 32'(err_collision), 32'(vis_coll));
                chk("err_bad_id", -1, 32'(err_bad_id), 32'(vis_bad));
            end
        end
    end

    initial begin
        mon_en = 0;
        rst_n  = 1'b0;
        err_clr = 1'b0;
        model_reset();
        idle();
        set_ready(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            l_valid[i] = 1'b0; l_id[i] = '0; l_tag[i] = '0; l_data[i] = '0; p_ready[i] = 1'b1;
        end

        // Reset held with every lane valid: nothing may leak out
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                l_valid[i] = 1'b1;
                l_id[i]    = ID_W'(i + 1);
                l_tag[i]   = TAG_W'($urandom_range(0, 3));
                l_data[i]  = WIDTH'($urandom_range(0, 255));
            end
            #2;
            for (int p = 0; p < 3; p++) begin
                chk("rst_valid", p, 32'(p_valid[p]), 32'h0);
                chk("rst_data", p, 32'(p_out[p]), 32'h0);
                chk("rst_tag", p, 32'(p_tag[p]), 32'h0);
            end
            chk("rst_err", -1, 32'({err_overflow, err_collision, err_bad_id}), 32'h0);
        end
        step();
        rst_n  = 1'b1;
        mon_en = 1;

        // Basic steering
        idle(); set_ready(1'b0, 1'b0, 1'b0);
        set_lane(0, PORT_ID_3, 2'd2, 8'hA5);
        set_lane(1, PORT_ID_1, 2'd0, 8'h3C);
        step();
        idle(); step(); step();
        set_ready(1'b1, 1'b1, 1'b1); step(); step();

        // Collision on port 2, then clear
        idle(); set_ready(1'b0, 1'b0, 1'b0);
        set_lane(0, PORT_ID_2, 2'd1, 8'h11);
        set_lane(2, PORT_ID_2, 2'd3, 8'h22);
        step();
        idle(); step();
        s_clr = 1'b1; step();
        idle(); set_ready(1'b1, 1'b1, 1'b1); step(); step();

        // Overflow on port 1 with nobody draining
        idle(); set_ready(1'b0, 1'b0, 1'b0);
        set_lane(0, PORT_ID_1, 2'd0, 8'h01); step();
        set_lane(0, PORT_ID_1, 2'd1, 8'h02); step();
        set_lane(0, PORT_ID_1, 2'd2, 8'h03); step();
        idle(); step(); step();
        set_ready(1'b1, 1'b0, 1'b0); step(); step(); step();
        s_clr = 1'b1; step();
        idle(); step();

        // Same sequence, but the port drains during the third push
        set_ready(1'b0, 1'b0, 1'b0);
        set_lane(0, PORT_ID_1, 2'd0, 8'h01); step();
        set_lane(0, PORT_ID_1, 2'd1, 8'h02); step();
        set_ready(1'b1, 1'b0, 1'b0);
        set_lane(0, PORT_ID_1, 2'd2, 8'h03); step();
        idle(); step(); step(); step();

        // Bad ID
        idle(); set_ready(1'b0, 1'b0, 1'b0);
        set_lane(1, PORT_ID_INVALID, 2'd1, 8'h77); step();
        idle(); step();
        s_clr = 1'b1; step();
        idle(); step();

        // Mid-stream asynchronous reset with two responses queued on port 3
        set_lane(2, PORT_ID_3, 2'd1, 8'h5A); step();
        set_lane(2, PORT_ID_3, 2'd2, 8'h6B); step();
        idle(); step();
        @(posedge clk);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 2, 32'(p_valid[2]), 32'h0);
        chk("async_rst_data", 2, 32'(p_out[2]), 32'h0);
        model_reset();
        step();
        rst_n  = 1'b1;
        mon_en = 1;
        step(); step();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 3; l++) begin
                s_valid[l] = ($urandom_range(0, 3) != 0);
                s_id[l]    = ($urandom_range(0, 9) == 0) ? ID_W'(0) : ID_W'($urandom_range(1, 3));
                s_tag[l]   = TAG_W'($urandom_range(0, 3));
                s_data[l]  = WIDTH'($urandom_range(0, 255));
                s_ready[l] = ($urandom_range(0, 2) != 0);
            end
            s_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        // Drain
        idle(); set_ready(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step();
        end
        @(negedge clk);
        #4;
        for (int p = 0; p < 3; p++) begin
            chk("final_empty", p, 32'(exp_q[p].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
